// File: rtl/cello_tt_pkg.sv
// cello_tt_pkg: shared states, truth-table geometry and row-to-signature-bit mapping
// for the truth-table sweeper.
package cello_tt_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

    localparam int TT_ROWS  = 8;
    localparam int TT_ROW_W = 3;

    // Row 000 lands in signature bit 7, so the signature reads like the gate's hex name.
    function automatic logic [TT_ROW_W-1:0] row_to_bit(input logic [TT_ROW_W-1:0] row);
        return TT_ROW_W'(TT_ROWS - 1) - row;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: counts settle cycles for one truth-table row and flags the last one.
module tt_settle_timer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb count_d = clear ? '0 : enable ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign expired = count_q == CNT_W'(SETTLE_CYCLES - 1);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a 3-input gate through all 8 rows, samples its output
// after a settle time and checks the resulting signature against EXPECTED.
module truth_table_sweeper
    import cello_tt_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [7:0] EXPECTED      = 8'hAC,
    parameter int         CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] signature,
    output logic       match
);

    // With no settle time each row goes straight to its sample cycle.
    localparam state_e ROW_START = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_e               state_q, state_d;
    logic [TT_ROW_W-1:0]  row_q, row_d;
    logic [TT_ROWS-1:0]   signature_q, signature_d;
    logic                 match_q, match_d;
    logic                 expired;

    tt_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != SETTLE || abort),
        .enable (state_q == SETTLE),
        .expired(expired)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        signature_d = signature_q;
        match_d     = match_q;
        if (abort && state_q != IDLE) begin
            state_d     = IDLE;
            row_d       = '0;
            signature_d = '0;
            match_d     = 1'b0;
        end else if (state_q == IDLE) begin
            if (start && !abort) begin
                state_d     = ROW_START;
                row_d       = '0;
                signature_d = '0;
                match_d     = 1'b0;
            end
        end else if (state_q == SETTLE) begin
            if (expired) state_d = SAMPLE;
        end else if (state_q == SAMPLE) begin
            signature_d[row_to_bit(row_q)] = dut_out;
            if (row_q == TT_ROW_W'(TT_ROWS - 1)) begin
                state_d = DONE;
                row_d   = '0;
                match_d = signature_d == EXPECTED;
            end else begin
                state_d = ROW_START;
                row_d   = row_q + 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            signature_q <= '0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            signature_q <= signature_d;
            match_q     <= match_d;
        end
    end

    assign {dut_in1, dut_in2, dut_in3} = row_q;
    assign busy      = state_q == SETTLE || state_q == SAMPLE;
    assign done      = state_q == DONE && !abort;
    assign signature = signature_q;
    assign match     = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: randomized sweeps of modelled gates against a cycle-count
// reference, on a default-settle sweeper and a zero-settle sweeper.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [7:0] tt_a = 8'hAC, tt_b = 8'hAC;
    logic       a_in1, a_in2, a_in3, a_out, a_busy, a_done, a_match;
    logic       b_in1, b_in2, b_in3, b_out, b_busy, b_done, b_match;
    logic [7:0] a_sig, b_sig;
    logic       sel = 1'b0;
    logic       s_busy, s_done, s_match;
    logic [2:0] s_row;
    logic [7:0] s_sig;
    logic [7:0] last_sig = 8'h00;
    logic       last_match = 1'b0;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    // Gate models: output is the truth-table bit named by the row, MSB = row 000.
    assign a_out = tt_a[7 - int'({a_in1, a_in2, a_in3})];
    assign b_out = tt_b[7 - int'({b_in1, b_in2, b_in3})];

    truth_table_sweeper u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .dut_in1(a_in1), .dut_in2(a_in2), .dut_in3(a_in3), .dut_out(a_out),
        .busy(a_busy), .done(a_done), .signature(a_sig), .match(a_match)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .dut_in1(b_in1), .dut_in2(b_in2), .dut_in3(b_in3), .dut_out(b_out),
        .busy(b_busy), .done(b_done), .signature(b_sig), .match(b_match)
    );

    assign s_busy  = sel ? b_busy  : a_busy;
    assign s_done  = sel ? b_done  : a_done;
    assign s_match = sel ? b_match : a_match;
    assign s_sig   = sel ? b_sig   : a_sig;
    assign s_row   = sel ? {b_in1, b_in2, b_in3} : {a_in1, a_in2, a_in3};

    task automatic set_start(input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    task automatic set_abort(input logic v);
        if (sel) abort_b = v; else abort_a = v;
    endtask

    // mode 0: full sweep, 1: abort on row 3 in SETTLE, 2: rst on row 5 in SAMPLE
    task automatic run_sweep(input logic which, input logic [7:0] tt, input logic noise, input int mode);
        int per, fin;
        logic [2:0] exp_row;
        sel = which;
        per = which ? 1 : 5;
        fin = 8 * per + 1;
        if (which) tt_b = tt; else tt_a = tt;
        @(negedge clk);
        set_start(1'b1);
        for (int k = 1; k <= fin + 3; k++) begin
            @(negedge clk);
            exp_row = 3'((k - 1) / per);
            tests++;
            if (k < fin) begin
                if ({s_busy, s_done, s_row} !== {1'b1, 1'b0, exp_row}) begin
                    fails++;
                    $display("FAIL sweep k=%0d busy,done,row got %b,%b,%03b exp 1,0,%03b", k, s_busy, s_done, s_row, exp_row);
                end
            end else if (k == fin) begin
                if ({s_busy, s_done, s_row, s_sig, s_match} !== {1'b0, 1'b1, 3'b000, tt, tt == 8'hAC}) begin
                    fails++;
                    $display("FAIL done k=%0d busy,done,row,sig,match got %b,%b,%03b,%h,%b exp 0,1,000,%h,%b", k, s_busy, s_done, s_row, s_sig, s_match, tt, tt == 8'hAC);
                end
            end else begin
                if ({s_busy, s_done, s_row, s_sig, s_match} !== {1'b0, 1'b0, 3'b000, tt, tt == 8'hAC}) begin
                    fails++;
                    $display("FAIL after_done k=%0d busy,done,row,sig,match got %b,%b,%03b,%h,%b exp 0,0,000,%h,%b", k, s_busy, s_done, s_row, s_sig, s_match, tt, tt == 8'hAC);
                end
            end
            set_start(noise && ((k < fin) ? 1'($urandom_range(0, 1)) : (k == fin)));
            if (mode == 1 && k == 3 * per + 1) begin
                set_abort(1'b1);
                @(negedge clk);
                set_abort(1'b0);
                tests++;
                if ({s_busy, s_done, s_row, s_sig, s_match} !== 13'b0) begin
                    fails++;
                    $display("FAIL abort busy,done,row,sig,match got %b,%b,%03b,%h,%b exp all 0", s_busy, s_done, s_row, s_sig, s_match);
                end
                for (int j = 0; j < fin; j++) begin
                    @(negedge clk);
                    tests++;
                    if ({s_busy, s_done} !== 2'b00) begin
                        fails++;
                        $display("FAIL abort_no_done j=%0d busy,done got %b,%b exp 0,0", j, s_busy, s_done);
                    end
                end
                last_sig = 8'h00;
                last_match = 1'b0;
                return;
            end
            if (mode == 2 && k == 6 * per) begin
                rst = 1'b1;
                set_start(1'b1);
                set_abort(1'b1);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    tests++;
                    if ({s_busy, s_done, s_row, s_sig, s_match} !== 13'b0) begin
                        fails++;
                        $display("FAIL mid_reset j=%0d busy,done,row,sig,match got %b,%b,%03b,%h,%b exp all 0", j, s_busy, s_done, s_row, s_sig, s_match);
                    end
                end
                rst = 1'b0;
                set_start(1'b0);
                set_abort(1'b0);
                @(negedge clk);
                tests++;
                if ({s_busy, s_done} !== 2'b00) begin
                    fails++;
                    $display("FAIL post_reset busy,done got %b,%b exp 0,0", s_busy, s_done);
                end
                last_sig = 8'h00;
                last_match = 1'b0;
                return;
            end
        end
        last_sig = tt;
        last_match = tt == 8'hAC;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({a_busy, a_done, a_in1, a_in2, a_in3, a_sig, a_match, b_busy, b_done, b_in1, b_in2, b_in3, b_sig, b_match} !== 26'b0) begin
            fails++;
            $display("FAIL reset a:%b%b%b%b%b %h %b b:%b%b%b%b%b %h %b exp all 0", a_busy, a_done, a_in1, a_in2, a_in3, a_sig, a_match, b_busy, b_done, b_in1, b_in2, b_in3, b_sig, b_match);
        end
        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sweep_gates();
        run_sweep(1'b0, 8'hAC, 1'b0, 0);
        run_sweep(1'b0, 8'h01, 1'b0, 0);
        repeat (4) run_sweep(1'b0, 8'($urandom), 1'b0, 0);
    endtask

    task automatic test_settle_zero();
        run_sweep(1'b1, 8'hAC, 1'b0, 0);
        repeat (3) run_sweep(1'b1, 8'($urandom), 1'b0, 0);
    endtask

    task automatic test_start_while_busy();
        run_sweep(1'b0, 8'hAC, 1'b1, 0);
        run_sweep(1'b0, 8'($urandom), 1'b1, 0);
    endtask

    task automatic test_start_abort_idle();
        sel = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        abort_a = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            start_a = 1'b0;
            abort_a = 1'b0;
            tests++;
            if ({s_busy, s_done, s_row, s_sig, s_match} !== {5'b0, last_sig, last_match}) begin
                fails++;
                $display("FAIL start_abort_idle j=%0d busy,done,row,sig,match got %b,%b,%03b,%h,%b exp 0,0,000,%h,%b", j, s_busy, s_done, s_row, s_sig, s_match, last_sig, last_match);
            end
        end
    endtask

    task automatic test_abort();
        run_sweep(1'b0, 8'($urandom), 1'b0, 1);
        run_sweep(1'b0, 8'hAC, 1'b0, 0);
    endtask

    task automatic test_reset_mid_sweep();
        run_sweep(1'b0, 8'hAC, 1'b0, 2);
        run_sweep(1'b0, 8'h5A, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_sweep_gates();
        test_settle_zero();
        test_start_while_busy();
        test_start_abort_idle();
        test_abort();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
